// File: rtl/conv_stream_host_pkg.sv
// Shared constants and state encoding for the convolution engine stream host.
package conv_stream_host_pkg;

   localparam int WEIGHT_WIDTH   = 2;
   localparam int WEIGHT_HEIGHT  = 2;
   localparam int IMG_WIDTH      = 4;
   localparam int IMG_HEIGHT     = 4;
   localparam int PADDING        = 0;
   localparam int STRIDE         = 2;
   localparam int BITWIDTH       = 3;
   localparam int RESULT_WIDTH   = (IMG_WIDTH - WEIGHT_WIDTH + 2 * PADDING) / STRIDE + 1;
   localparam int RESULT_HEIGHT  = (IMG_HEIGHT - WEIGHT_HEIGHT + 2 * PADDING) / STRIDE + 1;
   localparam int EXPAND         = 2;
   localparam int TIMEOUT_CYCLES = 1024;

   localparam int N_IMG = IMG_WIDTH * IMG_HEIGHT;
   localparam int N_WEI = WEIGHT_WIDTH * WEIGHT_HEIGHT;
   localparam int N_IN  = N_IMG + N_WEI + 1;
   localparam int N_OUT = RESULT_WIDTH * RESULT_HEIGHT;
   localparam int RW    = EXPAND * BITWIDTH;

   localparam int IMG_BITS = N_IMG * BITWIDTH;
   localparam int WEI_BITS = N_WEI * BITWIDTH;
   localparam int RES_BITS = N_OUT * RW;

   localparam int IN_CNT_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int OUT_CNT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int TMO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [IN_CNT_W-1:0]  IN_LAST  = IN_CNT_W'(N_IN - 1);
   localparam logic [OUT_CNT_W-1:0] OUT_LAST = OUT_CNT_W'(N_OUT - 1);
   localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   // One-hot controller states.
   typedef enum logic [4:0] {
      LOAD     = 5'b00001,
      START    = 5'b00010,
      WAIT_ACK = 5'b00100,
      WAIT_FIN = 5'b01000,
      DRAIN    = 5'b10000
   } state_t;

endpackage

// File: rtl/conv_stream_host_if.sv
// Stream and engine bus bundle for the convolution stream host.
// Handshake: a word moves on a rising clk_en edge where valid and ready are
// both high; the sender keeps valid and data stable until that edge, and
// ready may change freely.
interface conv_stream_host_if;
   import conv_stream_host_pkg::*;

   logic                s_valid;
   logic                s_ready;
   logic [BITWIDTH-1:0] s_data;
   logic                m_valid;
   logic                m_ready;
   logic [RW-1:0]       m_data;
   logic                m_last;
   logic                conv_en;
   logic [IMG_BITS-1:0] img;
   logic [WEI_BITS-1:0] weight;
   logic [BITWIDTH-1:0] bias;
   logic [RES_BITS-1:0] result;
   logic                conv_fin;

   modport master (
      input  s_valid, s_data, m_ready, result, conv_fin,
      output s_ready, m_valid, m_data, m_last, conv_en, img, weight, bias
   );

   modport slave (
      output s_valid, s_data, m_ready, result, conv_fin,
      input  s_ready, m_valid, m_data, m_last, conv_en, img, weight, bias
   );
endinterface

// File: rtl/conv_stream_host_serializer.sv
// Captures the engine result into a shadow register and streams it out
// one RW-bit word at a time, least significant word first.
module conv_result_serializer
   import conv_stream_host_pkg::*;
(
   input  logic                clk_en,
   input  logic                rst_n,
   input  logic                cap,
   input  logic [RES_BITS-1:0] result,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [RW-1:0]       m_data,
   output logic                m_last,
   output logic                done
);

   logic [RES_BITS-1:0]  shadow_q;
   logic [OUT_CNT_W-1:0] out_cnt;
   logic                 valid_q;
   int                   out_idx;

   assign out_idx = int'(out_cnt);
   assign m_valid = valid_q;
   assign m_last  = valid_q && (out_cnt == OUT_LAST);
   assign done    = valid_q && m_ready && (out_cnt == OUT_LAST);

   // Shadow capture and output word counter; advance only on a handshake.
   always_ff @(posedge clk_en) begin
      if (!rst_n) begin
         shadow_q <= '0;
         out_cnt  <= '0;
         valid_q  <= 1'b0;
      end else if (cap) begin
         shadow_q <= result;
         out_cnt  <= '0;
         valid_q  <= 1'b1;
      end else if (valid_q && m_ready) begin
         if (out_cnt == OUT_LAST) begin
            out_cnt <= '0;
            valid_q <= 1'b0;
         end else begin
            out_cnt <= out_cnt + 1'b1;
         end
      end
   end

   // Current word select; zero while nothing is being presented.
   always_comb begin
      m_data = '0;
      if (valid_q) begin
         m_data = shadow_q[out_idx*RW +: RW];
      end
   end

endmodule

// File: rtl/conv_stream_host.sv
// Initiator-side host for the convolution engine: loads a word stream into
// the flat img/weight/bias buses, runs the start/finish handshake and then
// streams the captured result back out.
module conv_stream_host
   import conv_stream_host_pkg::*;
(
   input  logic               clk_en,
   input  logic               rst_n,
   conv_stream_host_if.master bus,
   output logic               busy,
   output logic               err_timeout,
   output state_t             state_dbg
);

   state_t              state_q;
   state_t              state_d;
   logic [IN_CNT_W-1:0] in_cnt;
   logic [TMO_W-1:0]    tmo_cnt;
   logic                conv_en_q;
   logic                err_q;
   logic [IMG_BITS-1:0] img_q;
   logic [WEI_BITS-1:0] weight_q;
   logic [BITWIDTH-1:0] bias_q;
   logic                accept;
   logic                cap;
   logic                tmo_hit;
   logic                ser_done;
   int                  in_idx;

   assign in_idx      = int'(in_cnt);
   assign bus.s_ready = (state_q == LOAD);
   assign bus.conv_en = conv_en_q;
   assign bus.img     = img_q;
   assign bus.weight  = weight_q;
   assign bus.bias    = bias_q;
   assign busy        = (state_q != LOAD);
   assign err_timeout = err_q;
   assign state_dbg   = state_q;

   // State register.
   always_ff @(posedge clk_en) begin
      if (!rst_n) state_q <= LOAD;
      else        state_q <= state_d;
   end

   // Next state plus single-cycle strobes for the datapath. A high conv_fin
   // in WAIT_ACK is the idle level, so completion is only looked for after
   // the engine has pulled it low.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      cap     = 1'b0;
      tmo_hit = 1'b0;
      case (state_q)
         LOAD: begin
            accept = bus.s_valid;
            if (bus.s_valid && (in_cnt == IN_LAST)) state_d = START;
         end
         START: state_d = WAIT_ACK;
         WAIT_ACK: begin
            if (!bus.conv_fin) begin
               state_d = WAIT_FIN;
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_hit = 1'b1;
               state_d = LOAD;
            end
         end
         WAIT_FIN: begin
            if (bus.conv_fin) begin
               cap     = 1'b1;
               state_d = DRAIN;
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_hit = 1'b1;
               state_d = LOAD;
            end
         end
         DRAIN: if (ser_done) state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   // Load path, start request, timeout counter and sticky error flag.
   always_ff @(posedge clk_en) begin
      if (!rst_n) begin
         in_cnt    <= '0;
         tmo_cnt   <= '0;
         conv_en_q <= 1'b0;
         err_q     <= 1'b0;
         img_q     <= '0;
         weight_q  <= '0;
         bias_q    <= '0;
      end else begin
         if (accept) begin
            if (in_idx < N_IMG)              img_q[in_idx*BITWIDTH +: BITWIDTH] <= bus.s_data;
            else if (in_idx < N_IMG + N_WEI) weight_q[(in_idx-N_IMG)*BITWIDTH +: BITWIDTH] <= bus.s_data;
            else                             bias_q <= bus.s_data;
            in_cnt <= (in_cnt == IN_LAST) ? '0 : in_cnt + 1'b1;
         end
         if (state_q == START) begin
            conv_en_q <= 1'b1;
         end else if (((state_q == WAIT_ACK) && !bus.conv_fin) || tmo_hit) begin
            conv_en_q <= 1'b0;
         end
         if (state_d != state_q) begin
            tmo_cnt <= '0;
         end else if ((state_q == WAIT_ACK) || (state_q == WAIT_FIN)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (tmo_hit) err_q <= 1'b1;
      end
   end

   conv_result_serializer u_ser (
      .clk_en  (clk_en),
      .rst_n   (rst_n),
      .cap     (cap),
      .result  (bus.result),
      .m_valid (bus.m_valid),
      .m_ready (bus.m_ready),
      .m_data  (bus.m_data),
      .m_last  (bus.m_last),
      .done    (ser_done)
   );

endmodule

// File: tb/tb_conv_stream_host.sv
// Bench for conv_stream_host: random frames, a stub engine and a result
// scoreboard fed from the stub and drained by an output monitor.
module tb_conv_stream_host;
   import conv_stream_host_pkg::*;

   logic   clk_en = 1'b0;
   logic   rst_n  = 1'b0;
   logic   busy;
   logic   err_timeout;
   state_t state_dbg;

   conv_stream_host_if bus();

   conv_stream_host dut (
      .clk_en      (clk_en),
      .rst_n       (rst_n),
      .bus         (bus.master),
      .busy        (busy),
      .err_timeout (err_timeout),
      .state_dbg   (state_dbg)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [RW:0]         exp_q[$];
   logic [BITWIDTH-1:0] frame_words[N_IN];
   logic [IMG_BITS-1:0] exp_img;
   logic [WEI_BITS-1:0] exp_weight;
   logic [BITWIDTH-1:0] exp_bias;

   logic [RES_BITS-1:0] stub_result = '0;
   bit                  stub_hang   = 1'b0;
   bit                  stub_abort  = 1'b0;
   int                  stub_phase  = 0;
   int                  stub_cnt    = 0;

   int          mready_mode     = 0;
   bit          chk_sready_next = 1'b0;
   bit          prev_stall      = 1'b0;
   logic [RW-1:0] prev_data;
   logic        prev_last;
   int          hs_cnt = 0;

   // ---------------- clock ----------------
   always #5 clk_en = ~clk_en;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- stub engine ----------------
   initial begin
      bus.conv_fin = 1'b1;
      bus.result   = '0;
      forever begin
         @(posedge clk_en);
         #1;
         if (stub_abort) begin
            stub_phase   = 0;
            bus.conv_fin = 1'b1;
            stub_abort   = 1'b0;
         end else begin
            case (stub_phase)
               0: if (bus.conv_en) begin
                  if (stub_hang) stub_phase = 3;
                  else begin
                     stub_cnt   = 1;
                     stub_phase = 1;
                  end
               end
               1: begin
                  if (stub_cnt == 0) begin
                     bus.conv_fin = 1'b0;
                     stub_cnt     = 9;
                     stub_phase   = 2;
                  end else begin
                     stub_cnt--;
                  end
               end
               2: begin
                  if (stub_cnt == 9) check("conv_en_drop_after_ack", bus.conv_en, 1'b0);
                  if (stub_cnt == 0) begin
                     bus.result   = stub_result;
                     bus.conv_fin = 1'b1;
                     for (int i = 0; i < N_OUT; i++) begin
                        logic [RES_BITS-1:0] sh;
                        logic                lastf;
                        sh    = stub_result >> (i * RW);
                        lastf = (i == N_OUT - 1);
                        exp_q.push_back({lastf, sh[RW-1:0]});
                     end
                     stub_phase = 4;
                  end else begin
                     stub_cnt--;
                  end
               end
               3: if (!bus.conv_en) stub_phase = 0;
               4: begin
                  check("m_valid_latency", bus.m_valid, 1'b1);
                  stub_phase = 0;
               end
               default: stub_phase = 0;
            endcase
         end
      end
   end

   // ---------------- m_ready driver ----------------
   initial begin
      bus.m_ready = 1'b1;
      forever begin
         @(posedge clk_en);
         #1;
         case (mready_mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = ~bus.m_ready;
            default: bus.m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // ---------------- output monitor / scoreboard ----------------
   initial begin
      logic [RW:0] e;
      forever begin
         @(negedge clk_en);
         if (chk_sready_next) begin
            check("s_ready_after_drain", bus.s_ready, 1'b1);
            chk_sready_next = 1'b0;
         end
         if (bus.m_valid) begin
            check("s_ready_low_in_drain", bus.s_ready, 1'b0);
            if (prev_stall) begin
               check("held_data", bus.m_data, prev_data);
               check("held_last", bus.m_last, prev_last);
            end
            if (bus.m_ready) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_word: got 0x%0h expected no word", bus.m_data);
               end else begin
                  e = exp_q.pop_front();
                  check("m_data", bus.m_data, e[RW-1:0]);
                  check("m_last", bus.m_last, e[RW]);
               end
               hs_cnt++;
               if (bus.m_last) begin
                  check("handshakes_per_frame", hs_cnt, N_OUT);
                  hs_cnt          = 0;
                  chk_sready_next = 1'b1;
               end
            end
            prev_stall = !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
         end else begin
            if (prev_stall) check("valid_held_while_stalled", bus.m_valid, 1'b1);
            prev_stall = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_word(input logic [BITWIDTH-1:0] w);
      int guard = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = w;
      @(negedge clk_en);
      while (!bus.s_ready && guard < 3000) begin
         @(negedge clk_en);
         guard++;
      end
      if (guard >= 3000) check("s_ready_wait", bus.s_ready, 1'b1);
      @(posedge clk_en);
      #1;
      bus.s_valid = 1'b0;
   endtask

   task automatic send_frame(input bit directed);
      for (int k = 0; k < N_IN; k++) begin
         if (directed) begin
            if (k < N_IMG)              frame_words[k] = BITWIDTH'(k % 8);
            else if (k < N_IMG + N_WEI) frame_words[k] = BITWIDTH'(k - N_IMG + 1);
            else                        frame_words[k] = BITWIDTH'(5);
         end else begin
            frame_words[k] = BITWIDTH'($urandom_range(0, (1 << BITWIDTH) - 1));
         end
      end
      exp_img    = '0;
      exp_weight = '0;
      for (int k = 0; k < N_IMG; k++) exp_img |= IMG_BITS'(frame_words[k]) << (k * BITWIDTH);
      for (int k = 0; k < N_WEI; k++) exp_weight |= WEI_BITS'(frame_words[N_IMG + k]) << (k * BITWIDTH);
      exp_bias = frame_words[N_IN - 1];
      for (int k = 0; k < N_IN; k++) begin
         if (!directed) repeat ($urandom_range(0, 2)) begin
            @(posedge clk_en);
            #1;
         end
         send_word(frame_words[k]);
      end
      @(negedge clk_en);
      check("conv_en_low_in_start", bus.conv_en, 1'b0);
      check("busy_after_load", busy, 1'b1);
      @(negedge clk_en);
      check("conv_en_latency", bus.conv_en, 1'b1);
      check("img_bus", bus.img, exp_img);
      check("weight_bus", bus.weight, exp_weight);
      check("bias_bus", bus.bias, exp_bias);
   endtask

   task automatic wait_idle();
      int g = 0;
      do begin
         @(negedge clk_en);
         g++;
      end while (!(state_dbg == LOAD && exp_q.size() == 0 && stub_phase == 0) && g < 3000);
      check("frame_complete", (g < 3000), 1'b1);
      @(posedge clk_en);
      #1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // ---------------- reset and main sequence ----------------
   initial begin
      int cnt;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk_en);
      #1;
      rst_n = 1'b1;
      @(negedge clk_en);
      check("rst_s_ready", bus.s_ready, 1'b1);
      check("rst_m_valid", bus.m_valid, 1'b0);
      check("rst_m_last", bus.m_last, 1'b0);
      check("rst_m_data", bus.m_data, '0);
      check("rst_conv_en", bus.conv_en, 1'b0);
      check("rst_img", bus.img, '0);
      check("rst_weight", bus.weight, '0);
      check("rst_bias", bus.bias, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_err", err_timeout, 1'b0);
      check("rst_state", state_dbg, LOAD);
      @(posedge clk_en);
      #1;

      // Directed frame with known result.
      mready_mode = 0;
      stub_result = 24'hABCDEF;
      send_frame(1'b1);
      check("weight_const", bus.weight, 12'o4321);
      check("bias_const", bus.bias, 3'd5);
      check("img_low_slots", bus.img[8:0], 9'o210);
      wait_idle();

      // Backpressure: m_ready toggling.
      mready_mode = 1;
      stub_result = RES_BITS'($urandom);
      send_frame(1'b0);
      wait_idle();

      // Random frames with random backpressure.
      mready_mode = 2;
      for (int f = 0; f < 4; f++) begin
         stub_result = RES_BITS'($urandom);
         send_frame(1'b0);
         wait_idle();
      end

      // Engine never acknowledges: timeout.
      mready_mode = 0;
      stub_hang   = 1'b1;
      send_frame(1'b0);
      cnt = 0;
      do begin
         @(negedge clk_en);
         cnt++;
      end while (!err_timeout && cnt < 1100);
      check("timeout_cycles", cnt, TIMEOUT_CYCLES);
      check("timeout_err", err_timeout, 1'b1);
      check("timeout_conv_en", bus.conv_en, 1'b0);
      check("timeout_state", state_dbg, LOAD);
      check("timeout_m_valid", bus.m_valid, 1'b0);
      check("timeout_s_ready", bus.s_ready, 1'b1);
      stub_hang = 1'b0;
      @(posedge clk_en);
      #1;
      wait_idle();

      // Next frame is still accepted with the sticky error set.
      stub_result = RES_BITS'($urandom);
      send_frame(1'b0);
      wait_idle();
      check("err_sticky", err_timeout, 1'b1);

      // Reset pulse while waiting for completion.
      stub_result = RES_BITS'($urandom);
      send_frame(1'b0);
      cnt = 0;
      do begin
         @(negedge clk_en);
         cnt++;
      end while (state_dbg != WAIT_FIN && cnt < 100);
      check("reach_wait_fin", state_dbg, WAIT_FIN);
      @(posedge clk_en);
      #1;
      rst_n      = 1'b0;
      stub_abort = 1'b1;
      @(posedge clk_en);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      hs_cnt = 0;
      @(negedge clk_en);
      check("mid_rst_conv_en", bus.conv_en, 1'b0);
      check("mid_rst_s_ready", bus.s_ready, 1'b1);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_err", err_timeout, 1'b0);
      check("mid_rst_m_valid", bus.m_valid, 1'b0);
      check("mid_rst_img", bus.img, '0);
      @(posedge clk_en);
      #1;
      wait_idle();

      // s_valid held high while the host is busy.
      mready_mode = 2;
      stub_result = RES_BITS'($urandom);
      send_frame(1'b0);
      bus.s_valid = 1'b1;
      bus.s_data  = BITWIDTH'($urandom_range(0, 7));
      cnt = 0;
      do begin
         @(negedge clk_en);
         cnt++;
         check("hold_img", bus.img, exp_img);
         check("hold_weight", bus.weight, exp_weight);
         check("hold_bias", bus.bias, exp_bias);
      end while (!(bus.m_valid && bus.m_ready && bus.m_last) && cnt < 300);
      @(posedge clk_en);
      #1;
      bus.s_valid = 1'b0;
      @(negedge clk_en);
      check("after_hold_state", state_dbg, LOAD);
      @(posedge clk_en);
      #1;
      stub_result = RES_BITS'($urandom);
      send_frame(1'b0);
      wait_idle();

      repeat (3) @(posedge clk_en);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
